// File: rtl/shrin_ctrl_pkg.sv
// Shared definitions for the SHRin stage sequencer: FSM states, control-table
// field positions and the power-on stage program.
package shrin_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int F_MODE_IMM   = 0;
    localparam int F_MODE_DLY   = 1;
    localparam int F_SLCIN0_IMM = 2;
    localparam int F_SLCIN0_DLY = 3;
    localparam int F_SLCADDR    = 4;
    localparam int F_CH_EN      = 5;
    localparam int CTRL_W       = 5;

    // Control bits of the default program; channel enables are added by the table.
    function automatic logic [CTRL_W-1:0] default_ctrl(input int stage);
        logic [CTRL_W-1:0] ctrl;
        ctrl               = '0;
        ctrl[F_MODE_IMM]   = (stage == 1) || (stage == 3);
        ctrl[F_MODE_DLY]   = (stage == 6) || (stage == 9);
        ctrl[F_SLCIN0_IMM] = (stage == 4) || (stage == 5);
        ctrl[F_SLCIN0_DLY] = (stage == 8) || (stage == 9);
        ctrl[F_SLCADDR]    = (stage >= 6) && (stage <= 10);
        return ctrl;
    endfunction

endpackage

// File: rtl/shrin_cfg_table.sv
// Per-stage control table: NUM_STAGES entries, reloaded with the default
// program on reset, one write port and one combinational read port.
module shrin_cfg_table
    import shrin_ctrl_pkg::*;
#(
    parameter int STAGE_W    = 4,
    parameter int NUM_STAGES = 11,
    parameter int NUM_CH     = 2,
    localparam int CFG_W     = NUM_CH + 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [STAGE_W-1:0] waddr_i,
    input  logic [CFG_W-1:0]   wdata_i,
    input  logic [STAGE_W-1:0] raddr_i,
    output logic [CFG_W-1:0]   rdata_o
);

    logic [CFG_W-1:0] entry_q [NUM_STAGES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (rst) begin
                entry_q[i] <= {{NUM_CH{1'b1}}, default_ctrl(i)};
            end else if (we_i && (waddr_i == STAGE_W'(i))) begin
                entry_q[i] <= wdata_i;
            end
        end
    end

    // Address decode instead of direct indexing keeps out-of-range reads at zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (raddr_i == STAGE_W'(i)) begin
                rdata_o = entry_q[i];
            end
        end
    end

endmodule

// File: rtl/control_shrin_seq.sv
// SHRin control sequencer: steps through NUM_STAGES stages per run and drives
// per-channel mode/slcin0/slcaddr from a programmable table, immediate or one stage late.
module control_shrin_seq
    import shrin_ctrl_pkg::*;
#(
    parameter int STAGE_W    = 4,
    parameter int NUM_STAGES = 11,
    parameter int NUM_CH     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    input  logic               cfg_we,
    input  logic [STAGE_W-1:0] cfg_addr,
    input  logic [NUM_CH+4:0]  cfg_data,
    output logic [STAGE_W-1:0] rd_stage,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [NUM_CH-1:0]  mode_SHRin,
    output logic [NUM_CH-1:0]  slcin0_SHRin,
    output logic [NUM_CH-1:0]  slcaddr_SHRin
);

    localparam int CFG_W = NUM_CH + 5;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [NUM_CH-1:0]  dm_q, dm_d;
    logic [NUM_CH-1:0]  ds_q, ds_d;
    logic               cfg_err_q, cfg_err_d;

    logic [CFG_W-1:0]   entry;
    logic [NUM_CH-1:0]  ch_en;
    logic [NUM_CH-1:0]  mode_imm, slcin0_imm, slcaddr_imm;
    logic               in_run;
    logic               cfg_accept;

    shrin_cfg_table #(
        .STAGE_W    (STAGE_W),
        .NUM_STAGES (NUM_STAGES),
        .NUM_CH     (NUM_CH)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cfg_accept),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_data),
        .raddr_i (stage_q),
        .rdata_o (entry)
    );

    assign in_run     = (state_q == ST_RUN);
    assign ch_en      = entry[F_CH_EN +: NUM_CH];
    assign cfg_accept = cfg_we && (state_q == ST_IDLE) && (cfg_addr <= LAST_STAGE);
    assign cfg_err_d  = cfg_we && !cfg_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            dm_q      <= '0;
            ds_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            dm_q      <= dm_d;
            ds_q      <= ds_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        dm_d    = '0;
        ds_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                stage_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    dm_d = dm_q;
                    ds_d = ds_q;
                end else begin
                    dm_d = {NUM_CH{entry[F_MODE_DLY]}} & ch_en;
                    ds_d = {NUM_CH{entry[F_SLCIN0_DLY]}} & ch_en;
                    if (stage_q == LAST_STAGE) begin
                        state_d = ST_DONE;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = '0;
            end
        endcase
    end

    // Delayed terms remain visible in DONE so the last stage's late term is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign mode_imm[gi]    = in_run && entry[F_MODE_IMM]   && ch_en[gi];
            assign slcin0_imm[gi]  = in_run && entry[F_SLCIN0_IMM] && ch_en[gi];
            assign slcaddr_imm[gi] = in_run && entry[F_SLCADDR]    && ch_en[gi];

            assign mode_SHRin[gi]    = mode_imm[gi] | dm_q[gi];
            assign slcin0_SHRin[gi]  = slcin0_imm[gi] | ds_q[gi];
            assign slcaddr_SHRin[gi] = slcaddr_imm[gi];
        end
    endgenerate

    assign rd_stage = stage_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign cfg_err  = cfg_err_q;

endmodule
